// File: rtl/core_featuremap_linebuf3.sv
// core_featuremap_linebuf3
// ------------------------
// Three-row line buffer in front of the 3x3 convolution filter cores. Pixels
// arrive in raster order from a show-ahead FIFO. The two previous rows are
// held in internal line memories. For every pixel of row 2 and later, one
// packed column {row r-2, row r-1, row r} at the same column is pushed into
// the downstream FIFO. Pixel data passes through unmodified.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   ff_rdata  in   [DWIDTH-1:0]   head pixel of upstream FIFO (valid when !ff_empty)
//   ff_rdreq  out                 pop upstream FIFO (pixel accepted this cycle)
//   ff_empty  in                  upstream FIFO empty
//   ff_wdata  out  [3*DWIDTH-1:0] packed column {r-2, r-1, r}
//   ff_wrreq  out                 push downstream FIFO
//   ff_full   in                  downstream FIFO full
module core_featuremap_linebuf3 #(
    parameter int DWIDTH = 32,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DWIDTH-1:0]     ff_rdata,
    output logic                  ff_rdreq,
    input  logic                  ff_empty,
    output logic [3*DWIDTH-1:0]   ff_wdata,
    output logic                  ff_wrreq,
    input  logic                  ff_full
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Line memories: lb0 holds row r-2, lb1 holds row r-1.
    logic [DWIDTH-1:0]   lb0_r [IMG_W];
    logic [DWIDTH-1:0]   lb1_r [IMG_W];

    logic [CW-1:0]       col_r;
    logic [RW-1:0]       row_r;
    logic [3*DWIDTH-1:0] out_data_r;
    logic                out_valid_r;

    logic                accept_s;
    logic                drain_s;
    logic                col_last_s;
    logic                row_last_s;
    logic                row_ge2_s;
    logic [DWIDTH-1:0]   lb0_rd_s;
    logic [DWIDTH-1:0]   lb1_rd_s;

    // Handshake decode and position flags.
    always_comb begin
        // The pending word must be able to leave (or be absent) before a new
        // pixel is taken, since only one output word can be held. The reset
        // term keeps the upstream FIFO untouched while reset is asserted.
        accept_s   = reset && !ff_empty && (!out_valid_r || !ff_full);
        drain_s    = out_valid_r && !ff_full;
        col_last_s = (col_r == CW'(IMG_W - 1));
        row_last_s = (row_r == RW'(IMG_H - 1));
        row_ge2_s  = (row_r >= RW'(2));
        lb0_rd_s   = lb0_r[col_r];
        lb1_rd_s   = lb1_r[col_r];
    end

    assign ff_rdreq = accept_s;
    assign ff_wrreq = drain_s;
    assign ff_wdata = out_data_r;

    // Line memory shift at the current column; deliberately never cleared,
    // because rows 0 and 1 of each frame rewrite every entry before use.
    always_ff @(posedge clock) begin
        if (accept_s) begin
            lb0_r[col_r] <= lb1_rd_s;
            lb1_r[col_r] <= ff_rdata;
        end
    end

    // Raster position counters; wrap at end of row and end of frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_r <= '0;
            row_r <= '0;
        end else if (accept_s) begin
            if (col_last_s) begin
                col_r <= '0;
                row_r <= row_last_s ? '0 : row_r + RW'(1);
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    // Output word register: a load wins over a drain so that a simultaneous
    // drain and load keeps the valid flag set with no bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (accept_s && row_ge2_s) begin
            out_data_r  <= {lb0_rd_s, lb1_rd_s, ff_rdata};
            out_valid_r <= 1'b1;
        end else if (drain_s) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_core_featuremap_linebuf3.sv
module tb_core_featuremap_linebuf3;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clock;
    logic          reset;
    logic [DW-1:0] ff_rdata;
    logic          ff_rdreq;
    logic          ff_empty;
    logic [3*DW-1:0] ff_wdata;
    logic          ff_wrreq;
    logic          ff_full;

    core_featuremap_linebuf3 #(.DWIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clock    (clock),
        .reset    (reset),
        .ff_rdata (ff_rdata),
        .ff_rdreq (ff_rdreq),
        .ff_empty (ff_empty),
        .ff_wdata (ff_wdata),
        .ff_wrreq (ff_wrreq),
        .ff_full  (ff_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: frame image seen so far, pixel position in frame,
    // queue of words produced but not yet written downstream.
    logic [DW-1:0]   img [H][W];
    int              pos;
    logic [3*DW-1:0] q[$];
    logic [3*DW-1:0] wlog[$];
    logic [DW-1:0]   src[$];
    bit              acc;
    int              cyc;
    int              acc20_cyc;
    int              first_wr_cyc;
    int              gap_pct;
    int              full_pct;
    int              bp_hold;
    int              held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3*DW-1:0] ref_word(input int off, input int r, input int c);
        logic [DW-1:0] a, b, d;
        a = DW'(off + (r - 2) * 16 + c);
        b = DW'(off + (r - 1) * 16 + c);
        d = DW'(off + r * 16 + c);
        return {a, b, d};
    endfunction

    task automatic push_frame(input int off);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                src.push_back(DW'(off + r * 16 + c));
    endtask

    task automatic drive();
        bit gap;
        gap      = ($urandom_range(99) < gap_pct);
        ff_empty = (src.size() == 0) || gap;
        ff_rdata = (src.size() != 0) ? src[0] : DW'($urandom);
        if (bp_hold > 0 && q.size() != 0 && q[0] == 24'h011121 && held < bp_hold) begin
            ff_full = 1'b1;
            held++;
        end else begin
            ff_full = ($urandom_range(99) < full_pct);
        end
    endtask

    // One clock: compare at the falling edge, advance the model, then drive
    // the next inputs just after the rising edge.
    task automatic cycle();
        bit exp_rd, exp_wr;
        int r, c;
        @(negedge clock);
        exp_rd = reset && !ff_empty && (q.size() == 0 || !ff_full);
        exp_wr = reset && q.size() != 0 && !ff_full;
        chk("rdreq", 32'(ff_rdreq), 32'(exp_rd));
        chk("wrreq", 32'(ff_wrreq), 32'(exp_wr));
        if (exp_wr) chk("wdata", 32'(ff_wdata), 32'(q[0]));
        if (ff_empty) chk("rd_while_empty", 32'(ff_rdreq), 32'd0);
        if (!reset) chk("wdata_in_reset", 32'(ff_wdata), 32'd0);
        if (bp_hold > 0 && ff_full && q.size() != 0 && q[0] == 24'h011121) begin
            chk("bp_wdata_hold", 32'(ff_wdata), 32'h011121);
            chk("bp_rdreq", 32'(ff_rdreq), 32'd0);
        end
        acc = 1'b0;
        if (!reset) begin
            q.delete();
            pos = 0;
        end else begin
            if (exp_wr) begin
                if (wlog.size() == 0) first_wr_cyc = cyc;
                wlog.push_back(q.pop_front());
            end
            if (exp_rd) begin
                r = pos / W;
                c = pos % W;
                img[r][c] = ff_rdata;
                if (r >= 2) q.push_back({img[r-2][c], img[r-1][c], ff_rdata});
                if (r == 2 && c == 0) acc20_cyc = cyc;
                pos = (pos + 1) % (W * H);
                acc = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        if (acc) void'(src.pop_front());
        drive();
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while ((src.size() != 0 || q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_done", 32'(src.size() + q.size()), 32'd0);
    endtask

    task automatic check_frames(input int nfr, input int off0, input int off1);
        int k;
        chk("word_count", 32'(wlog.size()), 32'(nfr * (H - 2) * W));
        k = 0;
        for (int f = 0; f < nfr; f++)
            for (int r = 2; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    if (k < wlog.size())
                        chk("sequence", 32'(wlog[k]), 32'(ref_word(f == 0 ? off0 : off1, r, c)));
                    k++;
                end
    endtask

    initial begin
        cyc = 0; pos = 0; gap_pct = 0; full_pct = 0; bp_hold = 0; held = 0;
        acc20_cyc = -100; first_wr_cyc = -1;
        reset = 1'b0; ff_empty = 1'b0; ff_full = 1'b0; ff_rdata = 8'h5A;

        // Reset values with live input and free output.
        #2;
        chk("rst_rdreq", 32'(ff_rdreq), 32'd0);
        chk("rst_wrreq", 32'(ff_wrreq), 32'd0);
        chk("rst_wdata", 32'(ff_wdata), 32'd0);
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b1;

        // Full frame, no stalls.
        push_frame(0);
        drive();
        wlog.delete();
        run_idle(200);
        check_frames(1, 0, 0);
        if (wlog.size() == 8) begin
            chk("first_word", 32'(wlog[0]), 32'h001020);
            chk("last_word", 32'(wlog[7]), 32'h132333);
        end
        chk("first_latency", 32'(first_wr_cyc - acc20_cyc), 32'd1);

        // Output backpressure on word 0x011121.
        bp_hold = 5; held = 0;
        push_frame(0);
        drive();
        wlog.delete();
        run_idle(200);
        check_frames(1, 0, 0);
        chk("bp_held_cycles", 32'(held), 32'd5);
        bp_hold = 0;

        // Random input gaps and random output stalls.
        gap_pct = 40; full_pct = 30;
        for (int f = 0; f < 3; f++) begin
            push_frame(0);
            drive();
            wlog.delete();
            run_idle(600);
            check_frames(1, 0, 0);
        end
        gap_pct = 0; full_pct = 0;

        // Back-to-back frames, second offset by 0x80.
        push_frame(0);
        push_frame(8'h80);
        drive();
        wlog.delete();
        run_idle(300);
        check_frames(2, 0, 8'h80);
        if (wlog.size() == 16) chk("frame2_first", 32'(wlog[8]), 32'h8090A0);

        // Reset mid-frame after pixel (2,1) is taken.
        push_frame(0);
        drive();
        for (int n = 0; n < 100 && pos != 10; n++) cycle();
        chk("reached_2_1", 32'(pos), 32'd10);
        reset = 1'b0;
        src.delete();
        ff_empty = 1'b0; ff_full = 1'b0; ff_rdata = 8'h33;
        #1;
        chk("mid_rst_wrreq", 32'(ff_wrreq), 32'd0);
        chk("mid_rst_rdreq", 32'(ff_rdreq), 32'd0);
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b1;
        push_frame(0);
        drive();
        wlog.delete();
        run_idle(200);
        check_frames(1, 0, 0);
        if (wlog.size() != 0) chk("post_rst_first", 32'(wlog[0]), 32'h001020);

        // Idle tail: nothing more should be produced.
        for (int i = 0; i < 5; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_featuremap_linebuf3.md
# core_featuremap_linebuf3

Three-row line buffer that feeds the 3x3 convolution filter cores of the feature-map pipeline. It pops one pixel per accepted cycle from a raster-order input FIFO and stores the two previous rows internally. For every pixel from row 2 onward it pushes one packed column triple `{row r-2, row r-1, row r}` at the same column into the filter's input FIFO. The packed triple is the 3*DWIDTH word that the conv2d filter stage consumes.

## Interface
- `DWIDTH`, 32: pixel width in bits.
- `IMG_W`, 32: feature-map width in pixels (≥2).
- `IMG_H`, 32: feature-map height in rows (≥3).
- `clock`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `ff_rdata`  in  DWIDTH  — head pixel of the upstream show-ahead FIFO; valid whenever `ff_empty`=0.
- `ff_rdreq`  out  1  — pop upstream FIFO; a pixel is accepted in every cycle where this is 1.
- `ff_empty`  in  1  — upstream FIFO empty.
- `ff_wdata`  out  3*DWIDTH  — packed column: [3D-1:2D]=row r-2, [2D-1:D]=row r-1, [D-1:0]=row r.
- `ff_wrreq`  out  1  — push to downstream FIFO.
- `ff_full`  in  1  — downstream FIFO full.

## Operation
- **Storage:** two register arrays `lb0[IMG_W]` (row r-2) and `lb1[IMG_W]` (row r-1), each DWIDTH wide, read asynchronously by column index.
- **Counters:**
  - `col` (clog2(IMG_W) bits) runs 0..IMG_W-1.
  - `row` (clog2(IMG_H) bits) runs 0..IMG_H-1.
- **Output register:** `out_data` (3*DWIDTH bits) with a valid flag `out_valid`.
- **Accept condition:** `accept = !ff_empty && (!out_valid || !ff_full)`. `ff_rdreq = accept` (combinational).
- **On accept of pixel p at (row, col):**
  - `lb0[col] <= lb1[col]` and `lb1[col] <= p`.
  - If `row ≥ 2`: `out_data <= {lb0[col], lb1[col], p}` using pre-update contents, and `out_valid <= 1`.
  - If `row < 2`: `out_valid` follows the drain rule below; no new output is produced.
  - `col` increments; at IMG_W-1 it wraps to 0 and `row` increments.
  - When `row` = IMG_H-1 and `col` = IMG_W-1, both counters wrap to 0. The next frame starts with no idle cycle.
- **Drain:** `ff_wrreq = out_valid && !ff_full` (combinational). `ff_wdata = out_data`.
  - Drain without a new load clears `out_valid`.
  - Drain together with a new load keeps `out_valid` = 1 and replaces the data.
- **Frame output count:** (IMG_H-2)*IMG_W words per frame, in raster order of their bottom-row pixel.
- **Line memories:** never cleared. Rows 0 and 1 of every frame overwrite them before any output is formed, so stale contents never reach `ff_wdata`.
- **No arithmetic:** pixel data is not modified; this is bit-exact forwarding.

## Timing
- **Reset values:**
  - Asserting `reset` (low) clears `col`, `row` and `out_valid`, and zeroes `out_data`.
  - As a result `ff_wrreq`=0 and `ff_wdata`=0.
  - `ff_rdreq` = `!ff_empty` while in reset-released state with `out_valid`=0.
  - During reset assertion `ff_rdreq` is forced to 0.
- **Latency:** a pixel accepted in cycle N appears on `ff_wdata` with `ff_wrreq`=1 in cycle N+1, provided `ff_full`=0 in N+1.
- **Throughput:** one pixel per cycle sustained when the input FIFO is non-empty and the output FIFO is not full.
- **Backpressure:** while `out_valid`=1 and `ff_full`=1:
  - `ff_rdreq`=0, and no counter or line-buffer state changes.
  - `out_data` holds until `ff_full` falls.
  - No word is lost or duplicated.
- **Simultaneous drain and accept:** in the same cycle (out_valid=1, ff_full=0, ff_empty=0), one word is written and the next is loaded, giving no bubble.
- **Empty input:** `ff_empty`=1 stalls counters; a pending `out_valid` still drains.
- **Reset mid-frame:** counters restart at (0,0), and any pending output word is discarded. The next accepted pixel is treated as row 0, col 0.

## Test plan
Bench uses DWIDTH=8, IMG_W=4, IMG_H=4, and pixel value = row*16+col.

- **Full frame, no stalls:** stream 16 pixels.
  - The first `ff_wrreq` is 1 cycle after pixel (2,0) is accepted, with `ff_wdata`=0x001020.
  - Exactly 8 words appear, the last being 0x132333.
- **Output backpressure:** hold `ff_full`=1 for 5 cycles while word 0x011121 is pending.
  - `ff_rdreq`=0 and `ff_wdata` stays stable throughout.
  - After release, 0x011121 is written once, followed by 0x021222.
- **Input gaps:** toggle `ff_empty` randomly over a frame.
  - The output sequence is identical to the no-stall run.
  - `ff_rdreq` is never 1 while `ff_empty`=1.
- **Back-to-back frames:** send two frames with the second offset by 0x80.
  - 16 words total.
  - The first word of frame 2 is 0x8090A0, with no mixing of frame-1 rows.
- **Reset mid-frame:** assert `reset` low after pixel (2,1) is accepted, then release and send a full frame.
  - `ff_wrreq`=0 during reset.
  - The next output is 0x001020, after pixel (2,0) of the new stream.
- **Reset values:** hold `reset` low with `ff_empty`=0 and `ff_full`=0.
  - `ff_rdreq`=0, `ff_wrreq`=0, `ff_wdata`=0.
